// File: rtl/clarvi_muldiv_sequencer_if.sv
// Execute-stage <-> M-extension unit handshake bundle.
// Handshake rules: an op is taken on a rising edge only when start=1, ready=1 and kill=0;
// the result is offered with result_valid=1 and stays unchanged until a rising edge sees
// result_ready=1 (or kill=1). result reads 0 whenever result_valid=0.
interface clarvi_muldiv_sequencer_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      op;
    logic            is32;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            kill;
    logic            ready;
    logic            busy;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;
    logic [1:0]      state_dbg;

    modport master (
        output start, op, is32, rs1_value, rs2_value, kill, result_ready,
        input  ready, busy, result_valid, result, state_dbg
    );

    modport slave (
        input  start, op, is32, rs1_value, rs2_value, kill, result_ready,
        output ready, busy, result_valid, result, state_dbg
    );
endinterface

// File: rtl/clarvi_muldiv_sequencer.sv
// Iterative RV64M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up applied on entry to DONE.
// Only XLEN=64 is supported.
module clarvi_muldiv_sequencer #(
    parameter int XLEN      = 64,
    parameter bit EARLY_OUT = 1'b1
) (
    input logic clock,
    input logic reset,
    clarvi_muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [6:0]        counter;
    logic [2*XLEN-1:0] a_reg;      // mul: multiplicand (shifts left); div: dividend/quotient in low half
    logic [2*XLEN-1:0] acc;        // mul: product accumulator; div: remainder in low half
    logic [XLEN-1:0]   b_reg;      // mul: multiplier (shifts right); div: divisor
    logic [XLEN-1:0]   result_reg;
    logic [2:0]        op_reg;
    logic              w_reg;
    logic              neg_r_reg;  // negate product (mul) or remainder (div)
    logic              neg_q_reg;  // negate quotient

    logic            accept, early, last_iter;
    logic            is_w_in, a_signed_in, b_signed_in, a_neg, b_neg;
    logic            div_zero, div_ovf, mul_zero;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, rs1_sext32, early_result;

    // Decode the issuing op: operand extension, magnitudes, signs and early-out cases.
    always_comb begin
        is_w_in     = bus.is32 & ((bus.op == 3'd0) | bus.op[2]);
        a_signed_in = (bus.op == 3'd1) | (bus.op == 3'd2) | (bus.op == 3'd4) | (bus.op == 3'd6);
        b_signed_in = (bus.op == 3'd1) | (bus.op == 3'd4) | (bus.op == 3'd6);
        rs1_sext32  = {{32{bus.rs1_value[31]}}, bus.rs1_value[31:0]};
        if (is_w_in) begin
            a_ext = a_signed_in ? rs1_sext32 : {32'b0, bus.rs1_value[31:0]};
            b_ext = b_signed_in ? {{32{bus.rs2_value[31]}}, bus.rs2_value[31:0]}
                                : {32'b0, bus.rs2_value[31:0]};
        end else begin
            a_ext = bus.rs1_value;
            b_ext = bus.rs2_value;
        end
        a_neg    = a_signed_in & a_ext[XLEN-1];
        b_neg    = b_signed_in & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = b_signed_in & bus.op[2] & (b_ext == '1) &
                   (a_ext == (is_w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        mul_zero = (a_ext == '0) | (b_ext == '0);
        early    = EARLY_OUT & (bus.op[2] ? (div_zero | div_ovf) : mul_zero);
        // Zero-operand multiply leaves this at 0; overflow remainder is 0 as well.
        early_result = '0;
        if (bus.op[2]) begin
            if (div_zero) begin
                early_result = bus.op[1] ? (is_w_in ? rs1_sext32 : bus.rs1_value) : '1;
            end else if (!bus.op[1]) begin
                early_result = a_ext;
            end
        end
        accept = bus.start & ~bus.kill & (state == ST_IDLE);
    end

    logic [2*XLEN-1:0] acc_step, a_step, prod_fix;
    logic [XLEN-1:0]   b_step, quo_fix, rem_fix, final_result;
    logic [XLEN:0]     shifted, diff;

    // One iteration step plus the sign-corrected result it would produce if it were the last.
    always_comb begin
        shifted = {acc[XLEN-1:0], a_reg[XLEN-1]};
        diff    = shifted - {1'b0, b_reg};
        if (op_reg[2]) begin
            acc_step = {{XLEN{1'b0}}, diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0]};
            a_step   = {{XLEN{1'b0}}, a_reg[XLEN-2:0], ~diff[XLEN]};
            b_step   = b_reg;
        end else begin
            acc_step = acc + (b_reg[0] ? a_reg : '0);
            a_step   = a_reg << 1;
            b_step   = b_reg >> 1;
        end
        prod_fix = neg_r_reg ? -acc_step : acc_step;
        quo_fix  = neg_q_reg ? -a_step[XLEN-1:0] : a_step[XLEN-1:0];
        rem_fix  = neg_r_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        final_result = '0;
        case (op_reg)
            3'd0:             final_result = w_reg ? {{32{prod_fix[31]}}, prod_fix[31:0]}
                                                   : prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_result = w_reg ? {{32{quo_fix[31]}}, quo_fix[31:0]} : quo_fix;
            default:          final_result = w_reg ? {{32{rem_fix[31]}}, rem_fix[31:0]} : rem_fix;
        endcase
        last_iter = (counter == (w_reg ? 7'd31 : 7'd63));
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; kill beats start and result_ready.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = early ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_iter) state_next = ST_DONE;
            ST_DONE: if (bus.result_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (bus.kill) state_next = ST_IDLE;
    end

    // Datapath: latch operands on acceptance, iterate while BUSY, capture result at DONE entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter    <= '0;
            a_reg      <= '0;
            acc        <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            w_reg      <= 1'b0;
            neg_r_reg  <= 1'b0;
            neg_q_reg  <= 1'b0;
        end else if (accept) begin
            counter   <= '0;
            acc       <= '0;
            b_reg     <= b_mag;
            op_reg    <= bus.op;
            w_reg     <= is_w_in;
            neg_r_reg <= bus.op[2] ? a_neg : (a_neg ^ b_neg);
            neg_q_reg <= (a_neg ^ b_neg) & ~div_zero;
            // A 32-bit dividend is left-aligned so its MSB enters the remainder first.
            a_reg     <= {{XLEN{1'b0}}, (bus.op[2] && is_w_in) ? {a_mag[31:0], 32'b0} : a_mag};
            if (early) result_reg <= early_result;
        end else if (bus.kill) begin
            counter <= '0;
        end else if (state == ST_BUSY) begin
            a_reg <= a_step;
            acc   <= acc_step;
            b_reg <= b_step;
            if (last_iter) begin
                result_reg <= final_result;
                counter    <= '0;
            end else begin
                counter <= counter + 7'd1;
            end
        end
    end

    assign bus.ready        = (state == ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.result_valid = (state == ST_DONE);
    assign bus.result       = (state == ST_DONE) ? result_reg : '0;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_clarvi_muldiv_sequencer.sv
// Bench for clarvi_muldiv_sequencer: directed vectors, randomized ops against a plain
// arithmetic reference model, kill/hold/back-to-back/reset-in-flight scenarios.
module tb_clarvi_muldiv_sequencer;
    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic [63:0] exp_q[$];

    clarvi_muldiv_sequencer_if bus();

    clarvi_muldiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: RISC-V M semantics using plain wide arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  a32, b32, q32, r32;
        logic [63:0]  q, r;
        logic         wf, sgn;
        wf  = w && (op == 3'd0 || op >= 3'd4);
        sgn = (op == 3'd4) || (op == 3'd6);
        a32 = a[31:0];
        b32 = b[31:0];
        case (op)
            3'd0: begin
                p = {64'b0, a} * {64'b0, b};
                return wf ? {{32{p[31]}}, p[31:0]} : p[63:0];
            end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b};             return p[127:64]; end
            default: begin
                if (wf) begin
                    if (b32 == 32'd0) begin
                        q32 = 32'hFFFF_FFFF; r32 = a32;
                    end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                        q32 = a32; r32 = 32'd0;
                    end else if (sgn) begin
                        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
                    end else begin
                        q32 = a32 / b32; r32 = a32 % b32;
                    end
                    return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
                end else begin
                    if (b == 64'd0) begin
                        q = '1; r = a;
                    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                        q = a; r = 64'd0;
                    end else if (sgn) begin
                        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
                    end else begin
                        q = a / b; r = a % b;
                    end
                    return op[1] ? r : q;
                end
            end
        endcase
    endfunction

    // Expected edges from the issuing edge to result_valid (early-out = 1, else N+1).
    function automatic int ref_latency(input logic [2:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic wf, early;
        wf = w && (op == 3'd0 || op >= 3'd4);
        if (op < 3'd4) begin
            early = wf ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
        end else if (wf) begin
            early = (b[31:0] == 32'd0) ||
                    ((op == 3'd4 || op == 3'd6) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        end else begin
            early = (b == 64'd0) ||
                    ((op == 3'd4 || op == 3'd6) && a == 64'h8000_0000_0000_0000 && b == '1);
        end
        return early ? 1 : (wf ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'hFFFF_FFFF_8000_0000;
            5:       return 64'($urandom_range(0, 20));
            6:       return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Driver: issue one op, scramble inputs after acceptance, wait (bounded) for result_valid.
    task automatic issue_and_wait(input logic [2:0] op, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res, output int lat);
        @(negedge clock);
        bus.start = 1'b1; bus.op = op; bus.is32 = w; bus.rs1_value = a; bus.rs2_value = b;
        @(posedge clock); #1;
        lat = 1;
        bus.start     = 1'b0;
        bus.op        = 3'($urandom_range(0, 7));
        bus.is32      = 1'($urandom_range(0, 1));
        bus.rs1_value = {$urandom, $urandom};
        bus.rs2_value = {$urandom, $urandom};
        while (bus.result_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        res = bus.result;
    endtask

    task automatic consume();
        @(negedge clock);
        bus.result_ready = 1'b1;
        @(posedge clock); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.is32 = 1'b0; bus.kill = 1'b0;
        bus.rs1_value = '0; bus.rs2_value = '0; bus.result_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100 || bus.result !== 64'd0) begin
            failures++;
            $display("FAIL reset_held: rbv=%b result=%h want rbv=100 result=0",
                     {bus.ready, bus.busy, bus.result_valid}, bus.result);
        end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100 || bus.result !== 64'd0) begin
            failures++;
            $display("FAIL reset_released: rbv=%b result=%h want rbv=100 result=0",
                     {bus.ready, bus.busy, bus.result_valid}, bus.result);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b, exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [63:0] res;
        int lat;
        v.push_back('{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65});
        v.push_back('{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        v.push_back('{3'd2, 1'b0, '1, 64'd2, '1, 65});
        v.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
        v.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65});
        v.push_back('{3'd4, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1});
        v.push_back('{3'd5, 1'b0, 64'd5, 64'd0, '1, 1});
        v.push_back('{3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1});
        v.push_back('{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 33});
        v.push_back('{3'd6, 1'b1, 64'h1_0000_0007, 64'hFFFF_FFFE, 64'd1, 33});
        v.push_back('{3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 33});
        v.push_back('{3'd0, 1'b0, 64'd0, 64'd123, 64'd0, 1});
        foreach (v[i]) begin
            issue_and_wait(v[i].op, v[i].w, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, v[i].exp);
            end
            checks++;
            if (lat != v[i].lat) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, v[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b, res, exp;
        int lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = pick_operand();
            b  = pick_operand();
            exp_q.push_back(ref_result(op, w, a, b));
            exp_lat = ref_latency(op, w, a, b);
            issue_and_wait(op, w, a, b, res, lat);
            exp = exp_q.pop_front();
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL random_result[%0d] op=%0d w=%0b a=%h b=%h: got %h want %h",
                         i, op, w, a, b, res, exp);
            end
            checks++;
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL random_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, exp_lat);
            end
            consume();
        end
    endtask

    task automatic test_kill();
        logic [63:0] res;
        int lat, seen;
        @(negedge clock);
        bus.start = 1'b1; bus.op = 3'd4; bus.is32 = 1'b0; bus.rs1_value = 64'd100; bus.rs2_value = 64'd7;
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock); bus.kill = 1'b1;
        @(posedge clock); #1 bus.kill = 1'b0;
        checks++;
        if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100) begin
            failures++;
            $display("FAIL kill_abort: rbv=%b want 100", {bus.ready, bus.busy, bus.result_valid});
        end
        seen = 0;
        repeat (70) begin
            @(posedge clock); #1;
            if (bus.result_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL kill_no_result: valid cycles=%0d want 0", seen);
        end
        issue_and_wait(3'd4, 1'b0, 64'd9, 64'd3, res, lat);
        checks++;
        if (res !== 64'd3 || lat != 65) begin
            failures++;
            $display("FAIL kill_next_op: got %h lat %0d want 3 lat 65", res, lat);
        end
        consume();
        // kill beats start in IDLE
        @(negedge clock);
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd5; bus.rs1_value = 64'd5; bus.rs2_value = 64'd0;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        checks++;
        if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100) begin
            failures++;
            $display("FAIL kill_over_start: rbv=%b want 100", {bus.ready, bus.busy, bus.result_valid});
        end
        // kill in DONE drops the result
        issue_and_wait(3'd5, 1'b0, 64'd5, 64'd0, res, lat);
        @(negedge clock); bus.kill = 1'b1; bus.result_ready = 1'b1;
        @(posedge clock); #1 bus.kill = 1'b0; bus.result_ready = 1'b0;
        checks++;
        if ({bus.ready, bus.result_valid} !== 2'b10 || bus.result !== 64'd0) begin
            failures++;
            $display("FAIL kill_in_done: rv=%b result=%h want rv=10 result=0",
                     {bus.ready, bus.result_valid}, bus.result);
        end
    endtask

    task automatic test_hold_and_back_to_back();
        logic [63:0] a, b, res, exp;
        int lat;
        a = {$urandom, $urandom} | 64'd1;
        b = {$urandom, $urandom} | 64'd1;
        exp = ref_result(3'd3, 1'b0, a, b);
        issue_and_wait(3'd3, 1'b0, a, b, res, lat);
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL hold_first: got %h want %h", res, exp);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            bus.start = 1'b1; bus.op = 3'($urandom_range(0, 7));
            bus.rs1_value = {$urandom, $urandom}; bus.rs2_value = {$urandom, $urandom};
            @(posedge clock); #1 bus.start = 1'b0;
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result !== exp) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%b result=%h want valid=1 result=%h",
                         k, bus.result_valid, bus.result, exp);
            end
        end
        // DONE with result_ready and start together: start waits for the next cycle
        @(negedge clock);
        bus.result_ready = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.is32 = 1'b0;
        bus.rs1_value = 64'd5; bus.rs2_value = 64'd0;
        @(posedge clock); #1 bus.result_ready = 1'b0;
        checks++;
        if ({bus.ready, bus.result_valid} !== 2'b10) begin
            failures++;
            $display("FAIL no_back_to_back: rv=%b want 10", {bus.ready, bus.result_valid});
        end
        @(posedge clock); #1 bus.start = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b1 || bus.result !== '1) begin
            failures++;
            $display("FAIL start_next_cycle: valid=%b result=%h want valid=1 result=ffffffffffffffff",
                     bus.result_valid, bus.result);
        end
        consume();
        // result_ready while idle does nothing
        consume();
        checks++;
        if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100) begin
            failures++;
            $display("FAIL idle_result_ready: rbv=%b want 100", {bus.ready, bus.busy, bus.result_valid});
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] res;
        int lat;
        @(negedge clock);
        bus.start = 1'b1; bus.op = 3'd0; bus.is32 = 1'b0; bus.rs1_value = 64'd3; bus.rs2_value = 64'd5;
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.result_valid} !== 3'b100 || bus.result !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_busy: rbv=%b result=%h want rbv=100 result=0",
                     {bus.ready, bus.busy, bus.result_valid}, bus.result);
        end
        @(negedge clock); reset = 1'b0;
        issue_and_wait(3'd0, 1'b0, 64'd3, 64'd5, res, lat);
        checks++;
        if (res !== 64'd15 || lat != 65) begin
            failures++;
            $display("FAIL after_reset_op: got %h lat %0d want f lat 65", res, lat);
        end
        consume();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_hold_and_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
